regfile_wport_arbiter: RTL and testbench

Arbiter and scoreboard for the single write port of the 32-entry integer register file. It shares the port between the in-order pipeline writeback stage (WB) and a long-latency unit (LLU, e.g. multiply/divide) that completes out of band. It tracks which destinations have an LLU result pending and raises read hazards to decode. It drives the register file's `regWrite`/write-address/data inputs from registered outputs, and the register file commits on the following negedge.

---
 rtl/regfile_wport_arbiter_if.sv | 38 +++
 rtl/regfile_wport_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wport_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle between the pipeline/LLU side and the register-file write-port arbiter.
// The arbiter is the slave; the pipeline and LLU drive the master side.
interface regfile_wport_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wb_valid;
  logic [4:0]            wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_stall;
  logic                  llu_issue_valid;
  logic [4:0]            llu_issue_rd;
  logic                  llu_issue_ready;
  logic                  llu_valid;
  logic [4:0]            llu_addr;
  logic [DATA_WIDTH-1:0] llu_data;
  logic                  llu_ready;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic                  rs_hazard;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [31:0]           busy_vec;

  modport master (
    output wb_valid, wb_addr, wb_data, llu_issue_valid, llu_issue_rd,
           llu_valid, llu_addr, llu_data, rs1_addr, rs2_addr,
    input  wb_stall, llu_issue_ready, llu_ready, rs_hazard,
           rf_we, rf_waddr, rf_wdata, busy_vec
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, llu_issue_valid, llu_issue_rd,
           llu_valid, llu_addr, llu_data, rs1_addr, rs2_addr,
    output wb_stall, llu_issue_ready, llu_ready, rs_hazard,
           rf_we, rf_waddr, rf_wdata, busy_vec
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between WB and a long-latency unit, with a
// pending-write scoreboard. Define RF_ARB_STARVE_EN to build the LLU anti-starvation counter.
module regfile_wport_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                    clk,
  input logic                    rst,
  regfile_wport_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  logic [31:0]           busy_reg;
  logic [31:0]           busy_next;
  logic [31:0]           set_vec;
  logic [31:0]           clr_vec;
  logic                  rf_we_reg;
  logic [4:0]            rf_waddr_reg;
  logic [DATA_WIDTH-1:0] rf_wdata_reg;

  logic wb_conflict;
  logic force_llu;
  logic wb_grant;
  logic llu_ready;
  logic llu_hs;
  logic issue_ready;
  logic issue_hs;

  assign wb_conflict = bus.wb_valid && (bus.wb_addr != 5'd0) && busy_reg[bus.wb_addr];
  assign wb_grant    = bus.wb_valid && !wb_conflict && !force_llu;
  assign llu_ready   = !wb_grant;
  assign llu_hs      = bus.llu_valid && llu_ready;
  assign issue_ready = (bus.llu_issue_rd == 5'd0) || !busy_reg[bus.llu_issue_rd];
  assign issue_hs    = bus.llu_issue_valid && issue_ready;

`ifdef RF_ARB_STARVE_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= 4'd0;
    end else if (!bus.llu_valid || llu_hs) begin
      starve_cnt_reg <= 4'd0;
    end else if (starve_cnt_reg != STARVE_MAX) begin
      starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

  assign force_llu = (starve_cnt_reg == STARVE_MAX);
`else
  assign force_llu = 1'b0;
`endif

  // x0 is never tracked, so its set/clear strobes are tied off.
  assign set_vec[0] = 1'b0;
  assign clr_vec[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    assign set_vec[gi] = issue_hs && (bus.llu_issue_rd == 5'(gi));
    assign clr_vec[gi] = llu_hs && (bus.llu_addr == 5'(gi));
  end

  // Set applied after clear: an issue always wins over a stray completion to the same rd.
  assign busy_next = (busy_reg & ~clr_vec) | set_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= 32'd0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= 5'd0;
      rf_wdata_reg <= '0;
    end else begin
      rf_we_reg <= (wb_grant && (bus.wb_addr != 5'd0)) ||
                   (llu_hs && (bus.llu_addr != 5'd0));
      if (wb_grant) begin
        rf_waddr_reg <= bus.wb_addr;
        rf_wdata_reg <= bus.wb_data;
      end else if (llu_hs) begin
        rf_waddr_reg <= bus.llu_addr;
        rf_wdata_reg <= bus.llu_data;
      end
    end
  end

  assign bus.wb_stall        = bus.wb_valid && !wb_grant;
  assign bus.llu_ready       = llu_ready;
  assign bus.llu_issue_ready = issue_ready;
  assign bus.rs_hazard       = ((bus.rs1_addr != 5'd0) && busy_reg[bus.rs1_addr]) ||
                               ((bus.rs2_addr != 5'd0) && busy_reg[bus.rs2_addr]);
  assign bus.rf_we           = rf_we_reg;
  assign bus.rf_waddr        = rf_waddr_reg;
  assign bus.rf_wdata        = rf_wdata_reg;
  assign bus.busy_vec        = busy_reg;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Scoreboard bench for regfile_wport_arbiter: expected register-file writes are queued
// with their due cycle and matched against rf_we/rf_waddr/rf_wdata as they appear.
module tb_regfile_wport_arbiter;
  localparam int DW  = 32;
  localparam int LIM = 4;
`ifdef RF_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  wr_t  exp_q[$];

  regfile_wport_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  regfile_wport_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] addr, input logic [DW-1:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.wb_valid        = 1'b0;
    bus.wb_addr         = 5'd0;
    bus.wb_data         = '0;
    bus.llu_issue_valid = 1'b0;
    bus.llu_issue_rd    = 5'd0;
    bus.llu_valid       = 1'b0;
    bus.llu_addr        = 5'd0;
    bus.llu_data        = '0;
    bus.rs1_addr        = 5'd0;
    bus.rs2_addr        = 5'd0;
  endtask

  // Output monitor: one line per observed write, matched against the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check_eq("missed_we", 64'(cyc), 64'(exp_q[0].cyc));
      void'(exp_q.pop_front());
    end
    if (bus.rf_we === 1'b1) begin
      $display("rf write cyc=%0d addr=%0d data=%h", cyc, bus.rf_waddr, bus.rf_wdata);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 64'(bus.rf_we), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 64'(bus.rf_waddr), 64'(e.addr));
        check_eq("wr_data", 64'(bus.rf_wdata), 64'(e.data));
        check_eq("wr_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    bit served;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_we", 64'(bus.rf_we), 64'd0);
    check_eq("rst_waddr", 64'(bus.rf_waddr), 64'd0);
    check_eq("rst_wdata", 64'(bus.rf_wdata), 64'd0);
    check_eq("rst_busy", 64'(bus.busy_vec), 64'd0);
    check_eq("rst_issue_ready", 64'(bus.llu_issue_ready), 64'd1);
    check_eq("rst_hazard", 64'(bus.rs_hazard), 64'd0);
    check_eq("rst_wb_stall", 64'(bus.wb_stall), 64'd0);
    check_eq("rst_llu_ready", 64'(bus.llu_ready), 64'd1);

    // Plain WB write
    tick();
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
    @(negedge clk);
    check_eq("wb_stall_free", 64'(bus.wb_stall), 64'd0);
    check_eq("llu_ready_wb", 64'(bus.llu_ready), 64'd0);
    push_wr(5'd5, 32'h1234);
    tick();
    idle();

    // Issue x7, hazard on rs1/rs2, re-issue blocked, completion clears next cycle
    bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd7;
    @(negedge clk);
    check_eq("issue7_ready", 64'(bus.llu_issue_ready), 64'd1);
    tick();
    bus.rs1_addr = 5'd7;
    @(negedge clk);
    check_eq("busy7", 64'(bus.busy_vec), 64'h80);
    check_eq("hazard_rs1", 64'(bus.rs_hazard), 64'd1);
    check_eq("reissue7_ready", 64'(bus.llu_issue_ready), 64'd0);
    tick();
    bus.llu_issue_valid = 1'b0;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd7;
    @(negedge clk);
    check_eq("hazard_rs2", 64'(bus.rs_hazard), 64'd1);
    tick();
    bus.rs1_addr = 5'd7;
    bus.llu_valid = 1'b1; bus.llu_addr = 5'd7; bus.llu_data = 32'hDEAD;
    @(negedge clk);
    check_eq("llu7_ready", 64'(bus.llu_ready), 64'd1);
    check_eq("hazard_same_cyc", 64'(bus.rs_hazard), 64'd1);
    push_wr(5'd7, 32'hDEAD);
    tick();
    bus.llu_valid = 1'b0;
    @(negedge clk);
    check_eq("hazard_cleared", 64'(bus.rs_hazard), 64'd0);
    check_eq("busy7_clear", 64'(bus.busy_vec), 64'd0);
    tick();
    idle();

    // Starvation: WB held every cycle, LLU waiting from round cycle 0
    for (int round = 0; round < 2; round++) begin
      served = 1'b0;
      for (int i = 0; i < 8; i++) begin
        bus.wb_valid  = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'(round * 16 + i);
        bus.llu_valid = !served; bus.llu_addr = 5'(11 + round); bus.llu_data = 32'hB000 + 32'(round);
        @(negedge clk);
        if (STARVE_ON && i == LIM) begin
          check_eq("starve_llu_ready", 64'(bus.llu_ready), 64'd1);
          check_eq("starve_wb_stall", 64'(bus.wb_stall), 64'd1);
          push_wr(5'(11 + round), 32'hB000 + 32'(round));
          served = 1'b1;
        end else begin
          check_eq("starve_llu_wait", 64'(bus.llu_ready), 64'd0);
          check_eq("starve_wb_go", 64'(bus.wb_stall), 64'd0);
          push_wr(5'd10, 32'(round * 16 + i));
        end
        tick();
      end
      if (!served) begin
        bus.wb_valid = 1'b0;
        @(negedge clk);
        check_eq("llu_idle_serve", 64'(bus.llu_ready), 64'd1);
        push_wr(5'(11 + round), 32'hB000 + 32'(round));
        tick();
      end
      idle();
    end

    // WAW: WB to a pending register waits for the LLU result
    bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd9;
    tick();
    idle();
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("waw_stall", 64'(bus.wb_stall), 64'd1);
      tick();
    end
    bus.llu_valid = 1'b1; bus.llu_addr = 5'd9; bus.llu_data = 32'h5555;
    @(negedge clk);
    check_eq("waw_stall_llu", 64'(bus.wb_stall), 64'd1);
    check_eq("waw_llu_ready", 64'(bus.llu_ready), 64'd1);
    push_wr(5'd9, 32'h5555);
    tick();
    bus.llu_valid = 1'b0;
    @(negedge clk);
    check_eq("waw_release", 64'(bus.wb_stall), 64'd0);
    push_wr(5'd9, 32'h1);
    tick();
    idle();

    // x0 traffic never writes and never marks busy
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hAA;
    @(negedge clk);
    check_eq("x0_wb_stall", 64'(bus.wb_stall), 64'd0);
    tick();
    idle();
    bus.llu_valid = 1'b1; bus.llu_addr = 5'd0; bus.llu_data = 32'hBB;
    bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd0;
    @(negedge clk);
    check_eq("x0_llu_ready", 64'(bus.llu_ready), 64'd1);
    check_eq("x0_issue_ready", 64'(bus.llu_issue_ready), 64'd1);
    tick();
    idle();
    @(negedge clk);
    check_eq("x0_busy", 64'(bus.busy_vec), 64'd0);

    // Simultaneous events: issue x12, then issue x13 + complete x12, then issue+WB on x14
    tick();
    bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd12;
    tick();
    bus.llu_issue_rd = 5'd13;
    bus.llu_valid = 1'b1; bus.llu_addr = 5'd12; bus.llu_data = 32'hC12;
    push_wr(5'd12, 32'hC12);
    tick();
    bus.llu_valid = 1'b0;
    bus.llu_issue_rd = 5'd14;
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd14; bus.wb_data = 32'h77;
    @(negedge clk);
    check_eq("sim_wb_stall", 64'(bus.wb_stall), 64'd0);
    push_wr(5'd14, 32'h77);
    tick();
    idle();
    @(negedge clk);
    check_eq("sim_busy", 64'(bus.busy_vec), 64'h6000);
    tick();
    bus.llu_valid = 1'b1; bus.llu_addr = 5'd13; bus.llu_data = 32'hC13;
    push_wr(5'd13, 32'hC13);
    tick();
    bus.llu_addr = 5'd14; bus.llu_data = 32'hC14;
    push_wr(5'd14, 32'hC14);
    tick();
    idle();

    // Reset mid-operation with x3/x4 busy and a WB grant in the same cycle
    bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd3;
    tick();
    bus.llu_issue_rd = 5'd4;
    tick();
    idle();
    @(negedge clk);
    check_eq("pre_rst_busy", 64'(bus.busy_vec), 64'h18);
    tick();
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd20; bus.wb_data = 32'h99;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check_eq("post_rst_busy", 64'(bus.busy_vec), 64'd0);
    check_eq("post_rst_we", 64'(bus.rf_we), 64'd0);
    check_eq("post_rst_waddr", 64'(bus.rf_waddr), 64'd0);

    tick();
    tick();
    @(negedge clk);
    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
